and_reduce_top: RTL and testbench

//   Eight-operand wide AND-reduction detector: q[0] is 1 only when every bit
//   of all eight WIDTH-bit inputs a..h is 1 (all-ones detect across the bus).
//   q is zero-extended to WIDTH bits so it drops onto WIDTH-wide datapaths.

---
 rtl/and_reduce_pkg.sv | 38 +++
 rtl/and_reduce_node.sv | 11 +
 rtl/and_reduce_top.sv | 70 +++++++
 tb/tb_and_reduce_top.sv | 139 +++++++++++++
 4 files changed

// File: rtl/and_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the wide AND-reduction tree.
package and_reduce_pkg;

    localparam int NUM_OPS = 8;

    function automatic int ipow(input int base, input int exp);
        int r;
        r = 1;
        for (int i = 0; i < exp; i++) begin
            r = r * base;
        end
        return r;
    endfunction

    // Number of node levels needed to reduce NUM_OPS*width bits with the given fan-in.
    function automatic int tree_levels(input int width, input int fanin);
        int levels;
        int span;
        levels = 0;
        span   = 1;
        while (span < NUM_OPS * width) begin
            span   = span * fanin;
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Bit offset of a level inside the flattened tree vector; level 0 is the padded input.
    function automatic int level_offset(input int level, input int levels, input int fanin);
        int off;
        off = 0;
        for (int j = 0; j < level; j++) begin
            off = off + ipow(fanin, levels - j);
        end
        return off;
    endfunction

endpackage

// File: rtl/and_reduce_node.sv
// Single AND-tree node: reduces FANIN bits to one.
module and_reduce_node #(
    parameter int FANIN = 2
) (
    input  logic [FANIN-1:0] in,
    output logic             out
);

    assign out = &in;

endmodule

// File: rtl/and_reduce_top.sv
// All-ones detector across eight WIDTH-bit operands, built as a tree of
// Port_Num-input AND nodes, with a zero-extended result and a registered copy.
module and_reduce_top
    import and_reduce_pkg::*;
#(
    parameter int Port_Num = 2,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_r
);

    localparam int NBITS  = NUM_OPS * WIDTH;
    localparam int LEVELS = tree_levels(WIDTH, Port_Num);
    localparam int PAD    = ipow(Port_Num, LEVELS);
    localparam int TOTAL  = level_offset(LEVELS + 1, LEVELS, Port_Num);

    // Every level is stored full-width so each node sees exactly Port_Num bits;
    // the spare input positions are tied to 1 and cannot affect the result.
    logic [TOTAL-1:0] tree;
    logic             result;

    assign tree[NBITS-1:0] = {a, b, c, d, e, f, g, h};

    generate
        if (PAD > NBITS) begin : g_pad
            assign tree[PAD-1:NBITS] = '1;
        end

        for (genvar k = 0; k < LEVELS; k++) begin : g_level
            localparam int NODES   = ipow(Port_Num, LEVELS - k - 1);
            localparam int IN_OFF  = level_offset(k, LEVELS, Port_Num);
            localparam int OUT_OFF = level_offset(k + 1, LEVELS, Port_Num);
            for (genvar n = 0; n < NODES; n++) begin : g_node
                and_reduce_node #(
                    .FANIN(Port_Num)
                ) u_node (
                    .in (tree[IN_OFF + n*Port_Num +: Port_Num]),
                    .out(tree[OUT_OFF + n])
                );
            end
        end
    endgenerate

    assign result = tree[TOTAL-1];

    always_comb begin
        q    = '0;
        q[0] = result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= '0;
        end else begin
            q_r <= q;
        end
    end

endmodule

// File: tb/tb_and_reduce_top.sv
// Directed self-checking bench for and_reduce_top across several fan-in/width configurations.
module tb_and_reduce_top;

    logic       clk;
    logic       rst;
    logic [6:0] a, b, c, d, e, f, g, h;
    logic [6:0] q, q_r;
    logic       a1, b1, c1, d1, e1, f1, g1, h1;
    logic       q3, q3_r, q8, q8_r;

    int compared;
    int mismatched;

    and_reduce_top #(.Port_Num(2), .WIDTH(7)) dut (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .q(q), .q_r(q_r)
    );

    and_reduce_top #(.Port_Num(3), .WIDTH(1)) dut3 (
        .clk(clk), .rst(rst),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
        .q(q3), .q_r(q3_r)
    );

    and_reduce_top #(.Port_Num(8), .WIDTH(1)) dut8 (
        .clk(clk), .rst(rst),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
        .q(q8), .q_r(q8_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] va, vb, vc, vd, ve, vf, vg, vh);
        a = va; b = vb; c = vc; d = vd;
        e = ve; f = vf; g = vg; h = vh;
        #1;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ra, rb, rc, rd, re, rf, rg, rh;
    logic [6:0] model;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        applyStimulus(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        {a1, b1, c1, d1, e1, f1, g1, h1} = 8'h00;
        waitEdge();
        checkOutput("reset_q_r", q_r, 7'h00);
        checkOutput("reset_q3_r", {6'b0, q3_r}, 7'h00);
        rst = 1'b0;

        applyStimulus(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        checkOutput("all_ones_q", q, 7'h01);
        waitEdge();
        checkOutput("all_ones_q_r", q_r, 7'h01);

        applyStimulus(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7E);
        checkOutput("miss_lsb_h_q", q, 7'h00);
        waitEdge();
        checkOutput("miss_lsb_h_q_r", q_r, 7'h00);

        applyStimulus(7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        checkOutput("miss_msb_a_q", q, 7'h00);

        applyStimulus(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h6F, 7'h7F, 7'h7F, 7'h7F);
        checkOutput("miss_mid_e_q", q, 7'h00);

        applyStimulus(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        checkOutput("all_zero_q", q, 7'h00);

        for (int i = 0; i < 10; i++) begin
            ra = 7'($urandom_range(0, 127)); rb = 7'($urandom_range(0, 127));
            rc = 7'($urandom_range(0, 127)); rd = 7'($urandom_range(0, 127));
            re = 7'($urandom_range(0, 127)); rf = 7'($urandom_range(0, 127));
            rg = 7'($urandom_range(0, 127)); rh = 7'($urandom_range(0, 127));
            // Every other vector starts near all-ones so the true case is also reached.
            if (i % 2 == 0) begin
                ra = 7'h7F; rb = 7'h7F; rc = 7'h7F; rd = 7'h7F;
                re = 7'h7F; rf = 7'h7F; rg = 7'h7F;
                rh = (i == 4) ? 7'h7F : (7'h7F & ~(7'h01 << (i % 7)));
            end
            applyStimulus(ra, rb, rc, rd, re, rf, rg, rh);
            model = {6'b0, &{ra, rb, rc, rd, re, rf, rg, rh}};
            checkOutput($sformatf("random_%0d_q", i), q, model);
        end

        applyStimulus(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        waitEdge();
        checkOutput("pre_rst_q_r", q_r, 7'h01);
        rst = 1'b1;
        waitEdge();
        checkOutput("mid_rst_q_r", q_r, 7'h00);
        checkOutput("mid_rst_q", q, 7'h01);
        rst = 1'b0;
        waitEdge();
        checkOutput("post_rst_q_r", q_r, 7'h01);

        {a1, b1, c1, d1, e1, f1, g1, h1} = 8'hFF;
        #1;
        checkOutput("fanin3_all_ones_q", {6'b0, q3}, 7'h01);
        checkOutput("fanin8_all_ones_q", {6'b0, q8}, 7'h01);
        waitEdge();
        checkOutput("fanin3_all_ones_q_r", {6'b0, q3_r}, 7'h01);
        checkOutput("fanin8_all_ones_q_r", {6'b0, q8_r}, 7'h01);

        {a1, b1, c1, d1, e1, f1, g1, h1} = 8'hFE;
        #1;
        checkOutput("fanin3_miss_h_q", {6'b0, q3}, 7'h00);
        checkOutput("fanin8_miss_h_q", {6'b0, q8}, 7'h00);

        {a1, b1, c1, d1, e1, f1, g1, h1} = 8'h7F;
        #1;
        checkOutput("fanin3_miss_a_q", {6'b0, q3}, 7'h00);
        checkOutput("fanin8_miss_a_q", {6'b0, q8}, 7'h00);
        waitEdge();
        checkOutput("fanin3_miss_q_r", {6'b0, q3_r}, 7'h00);
        checkOutput("fanin8_miss_q_r", {6'b0, q8_r}, 7'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
